// File: rtl/sparc_mem_arbiter.sv
// rtl/sparc_mem_arbiter.sv - round-robin fetch/data arbiter sequencing single-port RAM accesses
// Optional ARB_STATS_EN adds saturating wait and conflict counters.
module sparc_mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 9
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_moc,
  output logic              if_align_err,
  output logic [31:0]       if_data,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_type,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_moc,
  output logic              d_align_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [1:0]        mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant_d
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       if_wait_cnt,
  output logic [15:0]       d_wait_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_ERR} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_d_q, grant_d_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_d;
  logic        if_misaligned;
  logic        d_misaligned;

  assign if_misaligned = |if_addr[1:0];
  // Byte accesses are always aligned; reserved type is checked like a word.
  assign d_misaligned  = (d_type == 2'b00) ? 1'b0 :
                         (d_type == 2'b01) ? d_addr[0] : |d_addr[1:0];

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      grant_d_q <= 1'b0;
      if_data_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_d_q <= grant_d_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d_d = grant_d_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    pick_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          // On a conflict the requester that did not win last time goes first.
          pick_d    = d_req && !(if_req && grant_d_q);
          grant_d_d = pick_d;
          if (pick_d ? d_misaligned : if_misaligned) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!grant_d_q) begin
            if_data_d = mem_rdata;
          end else if (d_rw) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en       = 1'b0;
    mem_rw       = 1'b0;
    mem_type     = 2'b00;
    mem_addr     = '0;
    mem_wdata    = 32'd0;
    if_moc       = 1'b0;
    d_moc        = 1'b0;
    if_align_err = 1'b0;
    d_align_err  = 1'b0;
    busy         = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        if (grant_d_q) begin
          mem_rw    = d_rw;
          mem_type  = (d_type == 2'b11) ? 2'b10 : d_type;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end else begin
          mem_rw   = 1'b1;
          mem_type = 2'b10;
          mem_addr = if_addr;
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        if_moc = !grant_d_q;
        d_moc  = grant_d_q;
      end
      ST_ERR: begin
        if_align_err = !grant_d_q;
        d_align_err  = grant_d_q;
      end
      default: ;
    endcase
  end

  assign if_data = if_data_q;
  assign d_rdata = d_rdata_q;
  assign grant_d = grant_d_q;

`ifdef ARB_STATS_EN
  logic [15:0] if_wait_q, if_wait_d;
  logic [15:0] d_wait_q, d_wait_d;
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    if_wait_d  = if_wait_q;
    d_wait_d   = d_wait_q;
    conflict_d = conflict_q;
    // A requester waits whenever the other one owns the RAM outside IDLE.
    if (state_q != ST_IDLE && grant_d_q && if_req && if_wait_q != 16'hFFFF)
      if_wait_d = if_wait_q + 16'd1;
    if (state_q != ST_IDLE && !grant_d_q && d_req && d_wait_q != 16'hFFFF)
      d_wait_d = d_wait_q + 16'd1;
    if (state_q == ST_IDLE && if_req && d_req && conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      if_wait_q  <= 16'd0;
      d_wait_q   <= 16'd0;
      conflict_q <= 16'd0;
    end else begin
      if_wait_q  <= if_wait_d;
      d_wait_q   <= d_wait_d;
      conflict_q <= conflict_d;
    end
  end

  assign if_wait_cnt  = if_wait_q;
  assign d_wait_cnt   = d_wait_q;
  assign conflict_cnt = conflict_q;
`endif

endmodule
